// File: rtl/adc_pkg.sv
// Shared definitions for the ADC post-processing slice: code width, averager
// FSM states and the rounding helper used to form the window mean.
package adc_pkg;

  localparam int ADC_CODE_W = 10;

  typedef enum logic {
    IDLE,
    ACCUM
  } avg_state_e;

  // Round-half-up divide by 2^log2; log2 == 0 passes the sum through untouched.
  function automatic logic [31:0] round_shift(input logic [31:0] sum, input int log2);
    logic [31:0] res;
    if (log2 == 0) begin
      res = sum;
    end else begin
      res = (sum + (32'd1 << (log2 - 1))) >> log2;
    end
    return res;
  endfunction

endpackage

// File: rtl/adc_minmax_tracker.sv
// Running minimum/maximum of a sample window, with a snapshot register pair
// that captures the final extremes (including the sample arriving that cycle).
module adc_minmax_tracker
  import adc_pkg::*;
#(
  parameter int DATA_W = ADC_CODE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              update,
  input  logic              snapshot,
  input  logic [DATA_W-1:0] code,
  output logic [DATA_W-1:0] min_val,
  output logic [DATA_W-1:0] max_val
);

  logic [DATA_W-1:0] run_min;
  logic [DATA_W-1:0] run_max;
  logic [DATA_W-1:0] merged_min;
  logic [DATA_W-1:0] merged_max;

  always_comb begin
    merged_min = run_min;
    merged_max = run_max;
    if (update && (code < run_min)) merged_min = code;
    if (update && (code > run_max)) merged_max = code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_min <= '1;
      run_max <= '0;
    end else if (init) begin
      run_min <= '1;
      run_max <= '0;
    end else begin
      run_min <= merged_min;
      run_max <= merged_max;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_val <= '0;
      max_val <= '0;
    end else if (snapshot) begin
      min_val <= merged_min;
      max_val <= merged_max;
    end
  end

endmodule

// File: rtl/adc_code_averager.sv
// Windowed averager for ADC conversion codes: accumulates 2^LOG2_AVG samples,
// then presents rounded mean, min and max behind a valid/ready handshake.
module adc_code_averager
  import adc_pkg::*;
#(
  parameter int DATA_W   = ADC_CODE_W,
  parameter int LOG2_AVG = 3
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              enable_i,
  input  logic [DATA_W-1:0] code_i,
  input  logic              code_valid_i,
  input  logic              clear_i,
  output logic [DATA_W-1:0] avg_o,
  output logic [DATA_W-1:0] min_o,
  output logic [DATA_W-1:0] max_o,
  output logic              avg_valid_o,
  input  logic              avg_ready_i,
  output logic              overrun_o
);

  localparam int ACC_W = DATA_W + LOG2_AVG;
  localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);

  avg_state_e        state;
  avg_state_e        state_next;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic [CNT_W-1:0]  cnt;
  logic              take;
  logic              abort;
  logic              win_end;
  logic              accept;
  logic [DATA_W-1:0] avg_next;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable_i)  state_next = ACCUM;
      ACCUM:   if (!enable_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    take    = (state == ACCUM) && enable_i && code_valid_i;
    abort   = (state == ACCUM) && !enable_i;
    win_end = take && (cnt == CNT_LAST);
  end

  // Final sample is folded in combinationally so the window closes on its own edge.
  always_comb begin
    acc_sum  = acc + ACC_W'(code_i);
    avg_next = DATA_W'(round_shift(32'(acc_sum), LOG2_AVG));
    accept   = avg_valid_o && avg_ready_i;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (abort || win_end) begin
      acc <= '0;
      cnt <= '0;
    end else if (take) begin
      acc <= acc_sum;
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      avg_o       <= '0;
      avg_valid_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (win_end) begin
        avg_o       <= avg_next;
        avg_valid_o <= 1'b1;
      end else if (accept) begin
        avg_valid_o <= 1'b0;
      end
      if (win_end && avg_valid_o && !avg_ready_i) overrun_o <= 1'b1;
      else if (clear_i)                           overrun_o <= 1'b0;
    end
  end

  adc_minmax_tracker #(
    .DATA_W(DATA_W)
  ) u_minmax (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n),
    .init     (abort || win_end),
    .update   (take),
    .snapshot (win_end),
    .code     (code_i),
    .min_val  (min_o),
    .max_val  (max_o)
  );

endmodule
